// File: rtl/zigbee_datapath_top.sv
// zigbee_datapath_top: dual 8x4 symbol FIFO datapath with strobe/side demux and registered observation muxes; ZB_TOP_ERR_FLAGS_EN enables sticky ovf/unf flags
module zigbee_datapath_top (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] in_inFIFO_inData,
    input  logic       in_outFIFO_inReadEnable,
    input  logic       in_DEMUX_inDEMUX1,
    input  logic       in_DEMUX_inDEMUX2,
    input  logic [3:0] in_DEMUX_inDEMUX17,
    input  logic [3:0] in_DEMUX_inDEMUX18,
    input  logic [2:0] in_DEMUX_inSEL1,
    input  logic       in_DEMUX_inSEL17,
    input  logic [1:0] in_MUX_inSEL6,
    input  logic [1:0] in_MUX_inSEL9,
    input  logic       in_MUX_inSEL11,
    input  logic       in_MUX_inSEL12,
    input  logic [2:0] in_MUX_inSEL15,
    output logic [3:0] out_MUX_outMUX9,
    output logic [3:0] out_MUX_outMUX10,
    output logic       out_MUX_outMUX15,
    output logic       out_MUX_outMUX16
);
    logic [3:0] r_in_mem [8];
    logic [3:0] r_out_mem [8];
    logic [2:0] r_in_wp, r_in_rp, r_out_wp, r_out_rp;
    logic [3:0] r_in_cnt, r_out_cnt;
    logic [3:0] r_reg_a, r_reg_b, r_rd_data;
    logic       r_b0, r_b1, r_rd_valid;
    logic       w_wr_req, w_xfer_req, w_flush;
    logic       w_in_empty, w_in_full, w_out_empty, w_out_full;
    logic       w_rd, w_xfer, w_wr, w_ovf, w_unf;
    logic [3:0] w_in_head, w_sum, w_mux9, w_mux10;
    logic [7:0] w_status;
    logic [3:0] w_flags16;

    assign w_wr_req    = in_DEMUX_inDEMUX1 && in_DEMUX_inSEL1 == 3'd0;
    assign w_xfer_req  = in_DEMUX_inDEMUX1 && in_DEMUX_inSEL1 == 3'd1;
    assign w_flush     = in_DEMUX_inDEMUX1 && in_DEMUX_inSEL1 == 3'd2;
    assign w_in_empty  = r_in_cnt == 4'd0;
    assign w_in_full   = r_in_cnt == 4'd8;
    assign w_out_empty = r_out_cnt == 4'd0;
    assign w_out_full  = r_out_cnt == 4'd8;
    // Flush wins over every FIFO operation in its cycle; a pop frees a slot for a same-cycle push.
    assign w_rd   = in_outFIFO_inReadEnable && !w_out_empty && !w_flush;
    assign w_xfer = w_xfer_req && !w_flush && !w_in_empty && (!w_out_full || w_rd);
    assign w_wr   = w_wr_req && !w_flush && (!w_in_full || w_xfer);

    // FIFO storage; stale entries are harmless because pointers and counts gate every access.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr) r_in_mem[r_in_wp] <= in_inFIFO_inData;
        if (!i_rst && w_xfer) r_out_mem[r_out_wp] <= r_in_mem[r_in_rp];
    end

    // Pointer and occupancy bookkeeping for both FIFOs.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_flush) begin
            r_in_wp   <= '0;
            r_in_rp   <= '0;
            r_in_cnt  <= '0;
            r_out_wp  <= '0;
            r_out_rp  <= '0;
            r_out_cnt <= '0;
        end else begin
            r_in_wp   <= r_in_wp + {2'b0, w_wr};
            r_in_rp   <= r_in_rp + {2'b0, w_xfer};
            r_in_cnt  <= r_in_cnt + {3'b0, w_wr} - {3'b0, w_xfer};
            r_out_wp  <= r_out_wp + {2'b0, w_xfer};
            r_out_rp  <= r_out_rp + {2'b0, w_rd};
            r_out_cnt <= r_out_cnt + {3'b0, w_xfer} - {3'b0, w_rd};
        end
    end

    // Output FIFO read port: data holds across idle cycles, valid pulses per successful pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd) r_rd_data <= r_out_mem[r_out_rp];
        end
    end

    // Side registers reload every cycle; SEL17 swaps operands and chooses which bit captures DEMUX2.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_reg_a <= '0;
            r_reg_b <= '0;
            r_b0    <= 1'b0;
            r_b1    <= 1'b0;
        end else begin
            r_reg_a <= in_DEMUX_inSEL17 ? in_DEMUX_inDEMUX18 : in_DEMUX_inDEMUX17;
            r_reg_b <= in_DEMUX_inSEL17 ? in_DEMUX_inDEMUX17 : in_DEMUX_inDEMUX18;
            if (in_DEMUX_inSEL17) r_b1 <= in_DEMUX_inDEMUX2;
            else r_b0 <= in_DEMUX_inDEMUX2;
        end
    end

`ifdef ZB_TOP_ERR_FLAGS_EN
    logic r_ovf, r_unf;
    // Sticky overflow/underflow, cleared only by reset or flush.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_flush) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_wr_req && w_in_full && !w_xfer) r_ovf <= 1'b1;
            if (in_outFIFO_inReadEnable && w_out_empty) r_unf <= 1'b1;
        end
    end
    assign w_ovf = r_ovf;
    assign w_unf = r_unf;
`else
    assign w_ovf = 1'b0;
    assign w_unf = 1'b0;
`endif

    assign w_in_head = w_in_empty ? 4'd0 : r_in_mem[r_in_rp];
    assign w_sum     = r_reg_a + r_reg_b;
    assign w_status  = {w_unf, w_ovf, r_b1, r_b0, w_out_full, w_out_empty, w_in_full, w_in_empty};
    assign w_flags16 = {r_rd_valid, r_b0 ^ r_b1, r_b1, r_b0};

    // Observation mux selection ahead of the output registers.
    always_comb begin
        w_mux9  = in_MUX_inSEL9 == 2'd0 ? r_rd_data :
                  in_MUX_inSEL9 == 2'd1 ? r_reg_a :
                  in_MUX_inSEL9 == 2'd2 ? r_reg_b : w_in_head;
        w_mux10 = in_MUX_inSEL6 == 2'd0 ? r_in_cnt :
                  in_MUX_inSEL6 == 2'd1 ? r_out_cnt :
                  in_MUX_inSEL6 == 2'd2 ? (r_reg_a ^ r_reg_b) : w_sum;
    end

    // Registered observation outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_MUX_outMUX9  <= '0;
            out_MUX_outMUX10 <= '0;
            out_MUX_outMUX15 <= 1'b0;
            out_MUX_outMUX16 <= 1'b0;
        end else begin
            out_MUX_outMUX9  <= w_mux9;
            out_MUX_outMUX10 <= w_mux10;
            out_MUX_outMUX15 <= w_status[in_MUX_inSEL15];
            out_MUX_outMUX16 <= w_flags16[{in_MUX_inSEL12, in_MUX_inSEL11}];
        end
    end
endmodule

// File: tb/tb_zigbee_datapath_top.sv
// tb_zigbee_datapath_top: directed self-checking bench for zigbee_datapath_top
module tb_zigbee_datapath_top;
`ifdef ZB_TOP_ERR_FLAGS_EN
    localparam logic [3:0] EF = 4'd1;
`else
    localparam logic [3:0] EF = 4'd0;
`endif
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] in_inFIFO_inData = '0;
    logic       in_outFIFO_inReadEnable = 1'b0;
    logic       in_DEMUX_inDEMUX1 = 1'b0;
    logic       in_DEMUX_inDEMUX2 = 1'b0;
    logic [3:0] in_DEMUX_inDEMUX17 = '0;
    logic [3:0] in_DEMUX_inDEMUX18 = '0;
    logic [2:0] in_DEMUX_inSEL1 = '0;
    logic       in_DEMUX_inSEL17 = 1'b0;
    logic [1:0] in_MUX_inSEL6 = '0;
    logic [1:0] in_MUX_inSEL9 = '0;
    logic       in_MUX_inSEL11 = 1'b0;
    logic       in_MUX_inSEL12 = 1'b0;
    logic [2:0] in_MUX_inSEL15 = '0;
    logic [3:0] out_MUX_outMUX9, out_MUX_outMUX10;
    logic       out_MUX_outMUX15, out_MUX_outMUX16;
    int         n_checks = 0;
    int         n_errors = 0;

    zigbee_datapath_top dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .in_inFIFO_inData(in_inFIFO_inData),
        .in_outFIFO_inReadEnable(in_outFIFO_inReadEnable),
        .in_DEMUX_inDEMUX1(in_DEMUX_inDEMUX1),
        .in_DEMUX_inDEMUX2(in_DEMUX_inDEMUX2),
        .in_DEMUX_inDEMUX17(in_DEMUX_inDEMUX17),
        .in_DEMUX_inDEMUX18(in_DEMUX_inDEMUX18),
        .in_DEMUX_inSEL1(in_DEMUX_inSEL1),
        .in_DEMUX_inSEL17(in_DEMUX_inSEL17),
        .in_MUX_inSEL6(in_MUX_inSEL6),
        .in_MUX_inSEL9(in_MUX_inSEL9),
        .in_MUX_inSEL11(in_MUX_inSEL11),
        .in_MUX_inSEL12(in_MUX_inSEL12),
        .in_MUX_inSEL15(in_MUX_inSEL15),
        .out_MUX_outMUX9(out_MUX_outMUX9),
        .out_MUX_outMUX10(out_MUX_outMUX10),
        .out_MUX_outMUX15(out_MUX_outMUX15),
        .out_MUX_outMUX16(out_MUX_outMUX16)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [2:0] lane, input logic [3:0] data, input int n);
        in_DEMUX_inSEL1 = lane;
        in_inFIFO_inData = data;
        in_DEMUX_inDEMUX1 = 1'b1;
        tick(n);
        in_DEMUX_inDEMUX1 = 1'b0;
    endtask

    task automatic read_one(input logic [3:0] exp, input string tag);
        in_outFIFO_inReadEnable = 1'b1;
        tick(1);
        in_outFIFO_inReadEnable = 1'b0;
        tick(1);
        check(tag, out_MUX_outMUX9, exp);
        check({tag, "_valid"}, out_MUX_outMUX16, 4'd1);
    endtask

    initial begin
        logic [3:0] wvals [3];
        wvals[0] = 4'b1101;
        wvals[1] = 4'b0011;
        wvals[2] = 4'b1111;
        tick(2);
        check("rst_mux9", out_MUX_outMUX9, 4'd0);
        check("rst_mux10", out_MUX_outMUX10, 4'd0);
        check("rst_mux15", out_MUX_outMUX15, 4'd0);
        check("rst_mux16", out_MUX_outMUX16, 4'd0);
        i_rst = 1'b0;
        tick(2);
        check("in_empty", out_MUX_outMUX15, 4'd1);
        in_MUX_inSEL15 = 3'd2;
        tick(1);
        check("out_empty", out_MUX_outMUX15, 4'd1);
        in_MUX_inSEL15 = 3'd1;
        tick(1);
        check("in_full_rst", out_MUX_outMUX15, 4'd0);

        for (int i = 0; i < 3; i++) strobe(3'd0, wvals[i], 1);
        in_MUX_inSEL6 = 2'd0;
        in_MUX_inSEL9 = 2'd3;
        tick(1);
        check("in_cnt3", out_MUX_outMUX10, 4'd3);
        check("in_head", out_MUX_outMUX9, 4'b1101);
        strobe(3'd1, 4'd0, 3);
        tick(1);
        check("in_cnt0", out_MUX_outMUX10, 4'd0);
        in_MUX_inSEL6 = 2'd1;
        tick(1);
        check("out_cnt3", out_MUX_outMUX10, 4'd3);
        in_MUX_inSEL9 = 2'd0;
        in_MUX_inSEL12 = 1'b1;
        in_MUX_inSEL11 = 1'b1;
        read_one(4'b1101, "rd0");
        read_one(4'b0011, "rd1");
        read_one(4'b1111, "rd2");
        tick(1);
        check("out_cnt0", out_MUX_outMUX10, 4'd0);
        check("rd_valid_idle", out_MUX_outMUX16, 4'd0);
        check("rd_hold", out_MUX_outMUX9, 4'b1111);

        for (int i = 1; i <= 9; i++) strobe(3'd0, 4'(i), 1);
        in_MUX_inSEL6 = 2'd0;
        in_MUX_inSEL9 = 2'd3;
        in_MUX_inSEL15 = 3'd1;
        tick(1);
        check("in_cnt8", out_MUX_outMUX10, 4'd8);
        check("in_full", out_MUX_outMUX15, 4'd1);
        check("head_first", out_MUX_outMUX9, 4'd1);
        in_MUX_inSEL15 = 3'd6;
        tick(1);
        check("ovf", out_MUX_outMUX15, EF);
        strobe(3'd1, 4'd0, 9);
        tick(1);
        check("in_drained", out_MUX_outMUX10, 4'd0);
        in_MUX_inSEL6 = 2'd1;
        in_MUX_inSEL15 = 3'd3;
        tick(1);
        check("out_cnt8", out_MUX_outMUX10, 4'd8);
        check("out_full", out_MUX_outMUX15, 4'd1);

        strobe(3'd0, 4'd7, 2);
        strobe(3'd2, 4'd0, 1);
        in_MUX_inSEL15 = 3'd6;
        tick(1);
        check("flush_out_cnt", out_MUX_outMUX10, 4'd0);
        check("flush_ovf", out_MUX_outMUX15, 4'd0);
        in_MUX_inSEL6 = 2'd0;
        in_MUX_inSEL15 = 3'd0;
        tick(1);
        check("flush_in_cnt", out_MUX_outMUX10, 4'd0);
        check("flush_in_empty", out_MUX_outMUX15, 4'd1);
        in_MUX_inSEL15 = 3'd7;
        tick(1);
        check("unf_clear", out_MUX_outMUX15, 4'd0);
        in_outFIFO_inReadEnable = 1'b1;
        tick(1);
        in_outFIFO_inReadEnable = 1'b0;
        tick(1);
        check("unf", out_MUX_outMUX15, EF);
        check("rd_empty_valid", out_MUX_outMUX16, 4'd0);

        in_DEMUX_inDEMUX17 = 4'b1101;
        in_DEMUX_inDEMUX18 = 4'b0110;
        in_DEMUX_inSEL17 = 1'b0;
        in_MUX_inSEL9 = 2'd1;
        in_MUX_inSEL6 = 2'd2;
        tick(2);
        check("reg_a", out_MUX_outMUX9, 4'b1101);
        check("xor", out_MUX_outMUX10, 4'b1011);
        in_MUX_inSEL6 = 2'd3;
        in_MUX_inSEL9 = 2'd2;
        tick(1);
        check("sum", out_MUX_outMUX10, 4'b0011);
        check("reg_b", out_MUX_outMUX9, 4'b0110);
        in_DEMUX_inSEL17 = 1'b1;
        in_MUX_inSEL9 = 2'd1;
        tick(2);
        check("reg_a_swap", out_MUX_outMUX9, 4'b0110);

        in_DEMUX_inDEMUX2 = 1'b1;
        in_DEMUX_inSEL17 = 1'b0;
        tick(1);
        in_DEMUX_inDEMUX2 = 1'b0;
        in_DEMUX_inSEL17 = 1'b1;
        tick(1);
        in_MUX_inSEL12 = 1'b1;
        in_MUX_inSEL11 = 1'b0;
        in_MUX_inSEL15 = 3'd4;
        tick(1);
        check("b0_xor_b1", out_MUX_outMUX16, 4'd1);
        check("b0_mux15", out_MUX_outMUX15, 4'd1);
        in_MUX_inSEL12 = 1'b0;
        in_MUX_inSEL15 = 3'd5;
        tick(1);
        check("b0", out_MUX_outMUX16, 4'd1);
        check("b1_mux15", out_MUX_outMUX15, 4'd0);
        in_MUX_inSEL11 = 1'b1;
        tick(1);
        check("b1", out_MUX_outMUX16, 4'd0);

        strobe(3'd0, 4'd5, 2);
        in_DEMUX_inDEMUX1 = 1'b1;
        i_rst = 1'b1;
        tick(1);
        in_DEMUX_inDEMUX1 = 1'b0;
        i_rst = 1'b0;
        in_MUX_inSEL6 = 2'd0;
        in_MUX_inSEL15 = 3'd0;
        tick(1);
        check("midrst_cnt", out_MUX_outMUX10, 4'd0);
        check("midrst_empty", out_MUX_outMUX15, 4'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
